// File: rtl/bist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST sequencer.
package bist_pkg;

  typedef enum logic [3:0] {
    IDLE,
    E0_W0_UP,
    E1_R0W1_UP,
    E2_R1W0_UP,
    E3_R0W1_DN,
    E4_R1W0_DN,
    E5_R0_DN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [2:0] ELEM_0 = 3'd0;
  localparam logic [2:0] ELEM_1 = 3'd1;
  localparam logic [2:0] ELEM_2 = 3'd2;
  localparam logic [2:0] ELEM_3 = 3'd3;
  localparam logic [2:0] ELEM_4 = 3'd4;
  localparam logic [2:0] ELEM_5 = 3'd5;

  // Backgrounds are replicated to the data width by the controller.
  localparam logic BG0 = 1'b0;
  localparam logic BG1 = 1'b1;

  typedef struct packed {
    logic up;
    logic has_read;
    logic has_write;
    logic rd_bg;
    logic wr_bg;
  } elem_cfg_t;

  // Indexed by element number; entries 6 and 7 are unused.
  localparam elem_cfg_t ELEM_TBL [8] = '{
    '{1'b1, 1'b0, 1'b1, BG0, BG0},
    '{1'b1, 1'b1, 1'b1, BG0, BG1},
    '{1'b1, 1'b1, 1'b1, BG1, BG0},
    '{1'b0, 1'b1, 1'b1, BG0, BG1},
    '{1'b0, 1'b1, 1'b1, BG1, BG0},
    '{1'b0, 1'b1, 1'b0, BG0, BG0},
    '{1'b0, 1'b0, 1'b0, BG0, BG0},
    '{1'b0, 1'b0, 1'b0, BG0, BG0}
  };

  function automatic logic is_elem(input state_t s);
    return (s == E0_W0_UP) || (s == E1_R0W1_UP) || (s == E2_R1W0_UP) ||
           (s == E3_R0W1_DN) || (s == E4_R1W0_DN) || (s == E5_R0_DN);
  endfunction

  function automatic logic [2:0] state_elem(input state_t s);
    case (s)
      E1_R0W1_UP: return ELEM_1;
      E2_R1W0_UP: return ELEM_2;
      E3_R0W1_DN: return ELEM_3;
      E4_R1W0_DN: return ELEM_4;
      E5_R0_DN:   return ELEM_5;
      default:    return ELEM_0;
    endcase
  endfunction

  function automatic state_t next_state(input state_t s);
    case (s)
      E0_W0_UP:   return E1_R0W1_UP;
      E1_R0W1_UP: return E2_R1W0_UP;
      E2_R1W0_UP: return E3_R0W1_DN;
      E3_R0W1_DN: return E4_R1W0_DN;
      E4_R1W0_DN: return E5_R0_DN;
      E5_R0_DN:   return DRAIN;
      default:    return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter for one march element; last marks the element's final address.
module bist_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_max,
  input  logic              step,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       addr <= '0;
    else if (load) addr <= {ADDR_W{load_max}};
    else if (step) addr <= up ? addr + 1'b1 : addr - 1'b1;
  end

  assign last = up ? (addr == {ADDR_W{1'b1}}) : (addr == {ADDR_W{1'b0}});

endmodule

// File: rtl/bist_march_ctrl.sv
// March C- sequencer owning the SRAM port during test; captures the first mismatch.
// state      | meaning
// IDLE       | out of reset, waiting for start
// E0_W0_UP   | write 0, ascending
// E1_R0W1_UP | read 0 / write 1, ascending
// E2_R1W0_UP | read 1 / write 0, ascending
// E3_R0W1_DN | read 0 / write 1, descending
// E4_R1W0_DN | read 1 / write 0, descending
// E5_R0_DN   | read 0, descending, compare one cycle behind
// DRAIN      | compare of the last E5 read
// DONE       | result held; start reruns
module bist_march_ctrl
  import bist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_we,
  output logic              sram_re,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);

  state_t            state, nxt_elem;
  logic              ph;
  elem_cfg_t         cur_cfg;
  logic              in_elem, rw_read, addr_end, last;
  logic              ag_load, ag_load_max, ag_step;
  logic              chk_valid;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_exp;
  logic [2:0]        chk_elem;

  // {re, we, din} for the first cycle spent on an address in state s.
  function automatic logic [DATA_W+1:0] first_op(input state_t s);
    logic [2:0] e;
    e = state_elem(s);
    first_op = '0;
    if (is_elem(s)) begin
      if (ELEM_TBL[e].has_read)
        first_op = {1'b1, 1'b0, {DATA_W{1'b0}}};
      else if (ELEM_TBL[e].has_write)
        first_op = {1'b0, 1'b1, {DATA_W{ELEM_TBL[e].wr_bg}}};
    end
  endfunction

  always_comb begin
    cur_cfg     = ELEM_TBL[state_elem(state)];
    nxt_elem    = next_state(state);
    in_elem     = is_elem(state);
    rw_read     = in_elem && cur_cfg.has_read && cur_cfg.has_write && !ph;
    addr_end    = in_elem && !rw_read;
    ag_load     = 1'b0;
    ag_load_max = 1'b0;
    ag_step     = 1'b0;
    if ((state == IDLE || state == DONE) && start) begin
      ag_load = 1'b1;
    end else if (addr_end && last && is_elem(nxt_elem)) begin
      ag_load     = 1'b1;
      ag_load_max = !ELEM_TBL[state_elem(nxt_elem)].up;
    end else if (addr_end && !last) begin
      ag_step = 1'b1;
    end
  end

  bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_max (ag_load_max),
    .step     (ag_step),
    .up       (cur_cfg.up),
    .addr     (sram_addr),
    .last     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ph        <= 1'b0;
      sram_re   <= 1'b0;
      sram_we   <= 1'b0;
      sram_din  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      chk_valid <= 1'b0;
      chk_addr  <= '0;
      chk_exp   <= '0;
      chk_elem  <= '0;
    end else begin
      // Read data returns the cycle after sram_re, so every compare trails its read by one.
      chk_valid <= sram_re;
      chk_addr  <= sram_addr;
      chk_exp   <= {DATA_W{cur_cfg.rd_bg}};
      chk_elem  <= state_elem(state);
      if (chk_valid && !fail && (sram_dout != chk_exp)) begin
        fail      <= 1'b1;
        fail_addr <= chk_addr;
        fail_elem <= chk_elem;
        fail_data <= sram_dout;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= E0_W0_UP;
            ph        <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
            {sram_re, sram_we, sram_din} <= first_op(E0_W0_UP);
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          {sram_re, sram_we, sram_din} <= '0;
        end
        default: begin
          if (rw_read) begin
            ph <= 1'b1;
            {sram_re, sram_we, sram_din} <= {1'b0, 1'b1, {DATA_W{cur_cfg.wr_bg}}};
          end else begin
            ph <= 1'b0;
            if (last) begin
              state <= nxt_elem;
              {sram_re, sram_we, sram_din} <= first_op(nxt_elem);
            end else begin
              {sram_re, sram_we, sram_din} <= first_op(state);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Bench for bist_march_ctrl: behavioural 256x4 SRAM with injectable stuck bits, trace and result scoreboards.
module tb_bist_march_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic              sram_we;
  logic              sram_re;
  logic [DATA_W-1:0] sram_dout = '0;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [DATA_W-1:0] fail_data;

  always #5 clk = ~clk;

  bist_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_we   (sram_we),
    .sram_re   (sram_re),
    .sram_dout (sram_dout),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data)
  );

  // Behavioural SRAM with up to two stuck bits applied on read.
  logic [3:0] mem [256];
  int         cyc = 0;
  logic       f1_en = 1'b0, f2_en = 1'b0;
  logic [7:0] f1_addr = '0, f2_addr = '0;
  int         f1_bit = 0, f2_bit = 0;
  logic       f1_val = 1'b0, f2_val = 1'b0;
  int         f2_from = 0;

  function automatic logic [3:0] faulty(input logic [7:0] a, input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (f1_en && a == f1_addr) r[f1_bit] = f1_val;
    if (f2_en && cyc >= f2_from && a == f2_addr) r[f2_bit] = f2_val;
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_we) mem[sram_addr] <= sram_din;
    if (sram_re) sram_dout <= faulty(sram_addr, mem[sram_addr]);
  end

  typedef struct packed {
    logic [7:0] addr;
    logic       we;
    logic       re;
    logic [3:0] din;
  } op_t;

  typedef struct packed {
    logic       fail;
    logic [2:0] elem;
    logic [7:0] addr;
    logic [3:0] data;
  } res_t;

  op_t  trace_q[$];
  res_t res_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   trace_idx = 0;
  logic trace_on = 1'b0;

  // Reference March C- port activity, one entry per cycle from the start edge.
  task automatic push_rw(input bit up, input logic [3:0] wv);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = up ? 8'(i) : 8'(255 - i);
      trace_q.push_back(op_t'{a, 1'b0, 1'b1, 4'h0});
      trace_q.push_back(op_t'{a, 1'b1, 1'b0, wv});
    end
  endtask

  task automatic push_trace();
    for (int i = 0; i < 256; i++) trace_q.push_back(op_t'{8'(i), 1'b1, 1'b0, 4'h0});
    push_rw(1'b1, 4'hF);
    push_rw(1'b1, 4'h0);
    push_rw(1'b0, 4'hF);
    push_rw(1'b0, 4'h0);
    for (int i = 0; i < 256; i++) trace_q.push_back(op_t'{8'(255 - i), 1'b0, 1'b1, 4'h0});
    trace_q.push_back(op_t'{8'h00, 1'b0, 1'b0, 4'h0});
  endtask

  always @(negedge clk) begin
    if (trace_on && trace_q.size() != 0) begin
      op_t e, o;
      e = trace_q.pop_front();
      o = op_t'{sram_addr, sram_we, sram_re, sram_din};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL trace[%0d]: got addr=%h we=%b re=%b din=%h, want addr=%h we=%b re=%b din=%h",
                 trace_idx, o.addr, o.we, o.re, o.din, e.addr, e.we, e.re, e.din);
      end
      trace_idx++;
    end
  end

  // Called at a negedge; returns edges from start sample to done (inclusive) and busy cycles.
  task automatic run_march(input int hold, input logic trc, output int lat, output int busy_n,
                           output logic fail0, output logic done0);
    int k;
    start = 1'b1;
    @(posedge clk);
    trace_on = trc;
    lat = 1;
    busy_n = 0;
    k = 0;
    fail0 = 1'bx;
    done0 = 1'bx;
    while (1) begin
      @(negedge clk);
      if (k == 0) begin
        fail0 = fail;
        done0 = done;
      end
      start = (k + 1 < hold);
      if (busy) busy_n++;
      if (done) break;
      if (lat >= 3000) begin
        n_tests++;
        n_fail++;
        $display("FAIL run_timeout: done still %b after %0d edges, want 1 by 2562", done, lat);
        break;
      end
      @(posedge clk);
      lat++;
      k++;
    end
    start = 1'b0;
    trace_on = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({sram_addr, sram_din, sram_we, sram_re, busy, done, fail, fail_addr, fail_elem, fail_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h din=%h we=%b re=%b busy=%b done=%b fail=%b fa=%h fe=%h fd=%h, want all 0",
               sram_addr, sram_din, sram_we, sram_re, busy, done, fail, fail_addr, fail_elem, fail_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fault_free_trace();
    int lat, bn;
    logic f0, d0;
    res_t exp, got;
    f1_en = 1'b0;
    f2_en = 1'b0;
    trace_q.delete();
    trace_idx = 0;
    push_trace();
    res_q.push_back(res_t'{1'b0, 3'd0, 8'h00, 4'h0});
    run_march(1, 1'b1, lat, bn, f0, d0);
    n_tests++;
    if (trace_q.size() != 0) begin
      n_fail++;
      $display("FAIL trace_len: %0d expected cycles not consumed, want 0", trace_q.size());
    end
    exp = res_q.pop_front();
    got = res_t'{fail, fail_elem, fail_addr, fail_data};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL clean_result: got fail=%b elem=%0d addr=%h data=%h, want fail=%b elem=%0d addr=%h data=%h",
               got.fail, got.elem, got.addr, got.data, exp.fail, exp.elem, exp.addr, exp.data);
    end
    n_tests++;
    if (lat !== 2562) begin
      n_fail++;
      $display("FAIL clean_latency: got %0d, want 2562", lat);
    end
    n_tests++;
    if (bn !== 2561) begin
      n_fail++;
      $display("FAIL clean_busy_cycles: got %0d, want 2561", bn);
    end
    n_tests++;
    if (busy !== 1'b0 || sram_we !== 1'b0 || sram_re !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_idle_at_done: got busy=%b we=%b re=%b, want 0 0 0", busy, sram_we, sram_re);
    end
  endtask

  task automatic test_stuck_at1();
    int lat, bn;
    logic f0, d0;
    res_t exp, got;
    f1_en = 1'b1; f1_addr = 8'h37; f1_bit = 0; f1_val = 1'b1;
    res_q.push_back(res_t'{1'b1, 3'd1, 8'h37, 4'b0001});
    run_march(1, 1'b0, lat, bn, f0, d0);
    f1_en = 1'b0;
    exp = res_q.pop_front();
    got = res_t'{fail, fail_elem, fail_addr, fail_data};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL sa1_result: got fail=%b elem=%0d addr=%h data=%h, want fail=%b elem=%0d addr=%h data=%h",
               got.fail, got.elem, got.addr, got.data, exp.fail, exp.elem, exp.addr, exp.data);
    end
    n_tests++;
    if (lat !== 2562 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL sa1_latency: got %0d done=%b, want 2562 done=1", lat, done);
    end
  endtask

  task automatic test_stuck_at0_second();
    int lat, bn;
    logic f0, d0;
    res_t exp, got;
    f1_en = 1'b1; f1_addr = 8'hFF; f1_bit = 3; f1_val = 1'b0;
    // The second cell goes bad during E3, after the first capture already happened.
    f2_en = 1'b1; f2_addr = 8'h10; f2_bit = 1; f2_val = 1'b1; f2_from = cyc + 1401;
    res_q.push_back(res_t'{1'b1, 3'd2, 8'hFF, 4'b0111});
    run_march(1, 1'b0, lat, bn, f0, d0);
    f1_en = 1'b0;
    f2_en = 1'b0;
    exp = res_q.pop_front();
    got = res_t'{fail, fail_elem, fail_addr, fail_data};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL sa0_first_only: got fail=%b elem=%0d addr=%h data=%h, want fail=%b elem=%0d addr=%h data=%h",
               got.fail, got.elem, got.addr, got.data, exp.fail, exp.elem, exp.addr, exp.data);
    end
    n_tests++;
    if (lat !== 2562) begin
      n_fail++;
      $display("FAIL sa0_latency: got %0d, want 2562", lat);
    end
  endtask

  task automatic test_restart_from_done();
    int lat, bn;
    logic f0, d0;
    res_t exp, got;
    res_q.push_back(res_t'{1'b0, 3'd0, 8'h00, 4'h0});
    run_march(1, 1'b0, lat, bn, f0, d0);
    n_tests++;
    if (f0 !== 1'b0 || d0 !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: got fail=%b done=%b after start edge, want 0 0", f0, d0);
    end
    exp = res_q.pop_front();
    got = res_t'{fail, fail_elem, fail_addr, fail_data};
    n_tests++;
    if (got !== exp || lat !== 2562) begin
      n_fail++;
      $display("FAIL restart_result: got fail=%b elem=%0d addr=%h data=%h lat=%0d, want clean lat=2562",
               got.fail, got.elem, got.addr, got.data, lat);
    end
  endtask

  task automatic test_start_held();
    int lat, bn;
    logic f0, d0;
    res_t exp, got;
    res_q.push_back(res_t'{1'b0, 3'd0, 8'h00, 4'h0});
    run_march(50, 1'b0, lat, bn, f0, d0);
    exp = res_q.pop_front();
    got = res_t'{fail, fail_elem, fail_addr, fail_data};
    n_tests++;
    if (lat !== 2562 || bn !== 2561) begin
      n_fail++;
      $display("FAIL held_start_timing: got lat=%0d busy=%0d, want 2562 2561", lat, bn);
    end
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL held_start_result: got fail=%b elem=%0d addr=%h data=%h, want clean",
               got.fail, got.elem, got.addr, got.data);
    end
  endtask

  task automatic test_async_reset_midrun();
    int lat, bn;
    logic f0, d0;
    res_t exp, got;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (599) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({sram_addr, sram_din, sram_we, sram_re, busy, done, fail, fail_addr, fail_elem, fail_data} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got addr=%h din=%h we=%b re=%b busy=%b done=%b fail=%b, want all 0",
               sram_addr, sram_din, sram_we, sram_re, busy, done, fail);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    res_q.push_back(res_t'{1'b0, 3'd0, 8'h00, 4'h0});
    run_march(1, 1'b0, lat, bn, f0, d0);
    exp = res_q.pop_front();
    got = res_t'{fail, fail_elem, fail_addr, fail_data};
    n_tests++;
    if (got !== exp || lat !== 2562 || bn !== 2561) begin
      n_fail++;
      $display("FAIL post_reset_run: got fail=%b addr=%h lat=%0d busy=%0d, want clean 2562 2561",
               got.fail, got.addr, lat, bn);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'($urandom_range(0, 15));
    test_reset();
    test_fault_free_trace();
    test_stuck_at1();
    test_stuck_at0_second();
    test_restart_from_done();
    test_start_held();
    test_async_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
